dmem_resp_ctrl: RTL
===================

Name: dmem_resp_ctrl

Overview:
- Parametrised, synthesizable data-memory responder for the RISC-V core's data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Successor to the fixed-latency bench memory model:
  - configurable load and store latency, memory depth and base address;
  - MMIO stdout and exit decode;
  - out-of-range error reporting;
  - a proper wait/ack FSM with abort handling.
- Sits between the top-level core and an internal byte-addressed memory array.
- Used by the bench and by FPGA bring-up.

Parameters:
- BIT_WIDTH, 32, data bus width (fixed 32 for the lane mapping below).
- ADDR_WIDTH, 32, address width.
- DEPTH_LOG2, 16, memory size is 2^DEPTH_LOG2 bytes.
- DMEM_START, 32'h8000_0000, base byte address of the memory.
- LOAD_LATENCY, 1, cycles from request sample to ACKD_n low for loads (>=1).
- STORE_LATENCY, 1, same for stores (>=1).
- STDOUT_ADDR, 32'hf000_0000, byte-store MMIO console address.
- EXIT_ADDR, 32'hff00_0000, any-size store here requests simulation/system exit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MREQ  in  1  data request valid, held until ACKD_n sampled low.
- WRITE  in  1  1=store, 0=load.
- SIZE  in  2  00 word, 01 half, 10/11 byte.
- DAD  in  ADDR_WIDTH  byte address.
- DDT  inout  BIT_WIDTH  store data in; load data driven only during the load ack cycle, else high-Z.
- ACKD_n  out  1  active-low access acknowledge, one cycle.
- stdout_valid  out  1  one-cycle pulse on an acknowledged byte store to STDOUT_ADDR.
- stdout_char  out  8  character, valid with stdout_valid.
- exit_req  out  1  sticky, set on a store to EXIT_ADDR.
- acc_err  out  1  one-cycle pulse with ACKD_n on an out-of-range or illegal access.

Behaviour:
- Reset (rst=0, asynchronous):
  - ACKD_n=1, stdout_valid=0, stdout_char=0, exit_req=0, acc_err=0.
  - FSM=IDLE, latency counter=0, DDT released.
  - Memory contents are not cleared.
- FSM states IDLE, WAIT, ACK.
  - IDLE: on MREQ=1, latch WRITE/SIZE/DAD, load counter with the selected latency minus 1.
    - Latency 1: go to ACK.
    - Otherwise go to WAIT.
  - WAIT: decrement the counter each cycle; on 0, go to ACK.
    - MREQ=0 in WAIT: abort to IDLE, no memory side effect, no ack.
    - WRITE, SIZE or DAD changed vs latched: restart the latency from the new request; stay in or re-enter WAIT.
  - ACK: ACKD_n=0 for exactly this cycle; the access is performed at the end of the cycle.
    - Next state IDLE.
    - If MREQ is still 1 at that edge, it is treated as a new request in IDLE on the following cycle; this gives one idle bubble between back-to-back accesses.
- Latency: ACKD_n is low in the cycle N after the edge that first sampled MREQ=1, where N = LOAD_LATENCY or STORE_LATENCY.
- Lane mapping (big-endian byte array m, a = DAD - DMEM_START):
  - Word: DDT = {m[a], m[a+1], m[a+2], m[a+3]}.
  - Half: bytes m[{a[hi:2],2'b10}-a[1:0]] and m[...+1] in DDT[15:8] and DDT[7:0]; DDT[31:16]=0.
  - Byte: m[{a[hi:2],2'b11}-a[1:0]] in DDT[7:0]; DDT[31:8]=0.
  - Stores use the same mapping in reverse; untouched bytes are preserved.
- MMIO:
  - Byte store to STDOUT_ADDR: no memory write; pulse stdout_valid with DDT[7:0].
  - Store of any size to EXIT_ADDR: set exit_req, acknowledged normally.
  - Loads from either address return 0 and are acknowledged.
- Range: an access with any byte outside [DMEM_START, DMEM_START + 2^DEPTH_LOG2 - 1] that is not MMIO:
  - is acknowledged with acc_err=1;
  - loads return 0;
  - stores are discarded.
- The top address byte is in range; a word at the last byte is out of range (no wrap-around).

Optional Feature:
- Macro DMEM_MISALIGN_CHK_EN.
- Defined: a word access with DAD[1:0]!=0 or a half access with DAD[0]!=0 is acknowledged with acc_err=1, performs no write, and returns 0.
- Undefined: the address is used as-is through the lane mapping above, with no error.

Decomposition:
- Package dmem_pkg:
  - SIZE encodings SZ_WORD/SZ_HALF/SZ_BYTE;
  - default STDOUT_ADDR/EXIT_ADDR;
  - FSM state typedef.
- Sub-module mem_lat_ctrl: parametrised latency counter plus IDLE/WAIT/ACK FSM with abort/restart. It is reusable for the instruction-fetch side (ACKI_n).

Test Plan:
- LOAD_LATENCY=3, preload m[0..3]=de ad be ef, word load at 8000_0000 -> ACKD_n low exactly 3 cycles after first MREQ sample, DDT=deadbeef for one cycle, then high-Z.
- Half store 0x1234 at 8000_0002 then word load at 8000_0000 -> 1234 in the bytes selected by the half mapping, other bytes unchanged, acc_err=0.
- Byte stores 'H','i' to f000_0000 -> two stdout_valid pulses with 0x48, 0x69; memory unchanged.
- STORE_LATENCY=4, MREQ dropped after 2 cycles -> no ACKD_n, memory unchanged; re-request -> ack after a full 4 cycles.
- Word load at 8000_0000+2^DEPTH_LOG2-2 -> ACKD_n=0, acc_err=1, DDT=0; store to ff00_0000 -> exit_req=1 and held.
- Reset asserted in WAIT -> immediate ACKD_n=1, FSM IDLE, exit_req cleared; with DMEM_MISALIGN_CHK_EN, word load at 8000_0001 -> acc_err=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: SIZE encodings, default
// MMIO addresses, latency FSM state encoding and a size helper.
package dmem_pkg;

  // SIZE bus encodings (2'b11 is also a byte access)
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Default MMIO decode addresses
  localparam logic [31:0] DEF_STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR   = 32'hff00_0000;

  // Latency FSM state encoding (plain constants for legacy tools)
  typedef logic [1:0] lat_state_t;
  localparam lat_state_t ST_IDLE = 2'd0;
  localparam lat_state_t ST_WAIT = 2'd1;
  localparam lat_state_t ST_ACK  = 2'd2;

  // Number of bytes touched by an access of the given SIZE
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_WORD: return 3'd4;
      SZ_HALF: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lat_ctrl.sv
// Generic request/acknowledge latency controller: IDLE/WAIT/ACK FSM with a
// down-counter, abort on request drop and restart when the request changes.
// Usable for both the data side (ACKD_n) and the fetch side (ACKI_n).
//
// Handshake: i_req is held by the requester until it sees o_ack; o_ack is
// high for exactly one cycle, and the request is complete at the end of that
// cycle. o_capture pulses on the edge where a new request is latched.
module mem_lat_ctrl
  import dmem_pkg::*;
#(
  parameter int LAT_RD = 1,
  parameter int LAT_WR = 1,
  parameter int CNT_W  = $clog2(((LAT_RD > LAT_WR) ? LAT_RD : LAT_WR) + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       i_is_wr,
  input  logic       i_req_chg,
  output logic       o_capture,
  output logic       o_ack,
  output lat_state_t o_state
);

  lat_state_t       r_state;
  lat_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_lat_m1;

  assign w_lat_m1 = i_is_wr ? CNT_W'(LAT_WR - 1) : CNT_W'(LAT_RD - 1);

  // Next-state and counter logic; a latency of 1 skips WAIT entirely
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          o_capture   = 1'b1;
          w_cnt_nxt   = w_lat_m1;
          w_state_nxt = (w_lat_m1 == '0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_req) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_req_chg) begin
          o_capture   = 1'b1;
          w_cnt_nxt   = w_lat_m1;
          w_state_nxt = (w_lat_m1 == '0) ? ST_ACK : ST_WAIT;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_ACK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_ack   = (r_state == ST_ACK);
  assign o_state = r_state;

endmodule

// File: rtl/dmem_resp_ctrl.sv
// Data-memory responder for the core's data bus. Holds a big-endian byte
// array at DMEM_START, decodes STDOUT/EXIT MMIO, flags out-of-range accesses
// and drives DDT only during a load acknowledge cycle.
// Optional macro DMEM_MISALIGN_CHK_EN: misaligned word/half accesses are
// acknowledged with acc_err, no write and zero read data.
module dmem_resp_ctrl
  import dmem_pkg::*;
#(
  parameter int                    BIT_WIDTH     = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEPTH_LOG2    = 16,
  parameter logic [ADDR_WIDTH-1:0] DMEM_START    = 32'h8000_0000,
  parameter int                    LOAD_LATENCY  = 1,
  parameter int                    STORE_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] STDOUT_ADDR   = DEF_STDOUT_ADDR,
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR     = DEF_EXIT_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MREQ,
  input  logic                  WRITE,
  input  logic [1:0]            SIZE,
  input  logic [ADDR_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0]  DDT,
  output logic                  ACKD_n,
  output logic                  stdout_valid,
  output logic [7:0]            stdout_char,
  output logic                  exit_req,
  output logic                  acc_err
);

  // Offsets are computed two bits wider so that addresses below DMEM_START
  // show up as negative and index arithmetic past the top never wraps.
  localparam int            XW        = ADDR_WIDTH + 2;
  localparam logic [XW-1:0] MEM_BYTES = XW'(1) << DEPTH_LOG2;

  logic                  r_write;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_dad;
  logic                  r_exit;
  logic [7:0]            r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_capture;
  logic                  w_ack;
  logic                  w_req_chg;
  lat_state_t            w_state;
  logic                  w_is_stdout;
  logic                  w_is_exit;
  logic                  w_is_mmio;
  logic [XW-1:0]         w_off;
  logic [XW-1:0]         w_lo;
  logic [2:0]            w_nbytes;
  logic                  w_in_range;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_mem_ok;
  logic [DEPTH_LOG2-1:0] w_idx0;
  logic [DEPTH_LOG2-1:0] w_idx1;
  logic [DEPTH_LOG2-1:0] w_idx2;
  logic [DEPTH_LOG2-1:0] w_idx3;
  logic [BIT_WIDTH-1:0]  w_rdata;

  // A change of any request field while waiting restarts the latency
  assign w_req_chg = (WRITE != r_write) || (SIZE != r_size) || (DAD != r_dad);

  mem_lat_ctrl #(
    .LAT_RD (LOAD_LATENCY),
    .LAT_WR (STORE_LATENCY)
  ) u_lat (
    .clk       (clk),
    .rst_n     (rst),
    .i_req     (MREQ),
    .i_is_wr   (WRITE),
    .i_req_chg (w_req_chg),
    .o_capture (w_capture),
    .o_ack     (w_ack),
    .o_state   (w_state)
  );

  // Latch the request fields whenever the FSM accepts a (new) request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_size  <= SZ_WORD;
      r_dad   <= '0;
    end else if (w_capture) begin
      r_write <= WRITE;
      r_size  <= SIZE;
      r_dad   <= DAD;
    end
  end

  // Address decode: MMIO, lane base index, range and alignment checks
  always_comb begin
    w_is_stdout = r_write && r_size[1] && (r_dad == STDOUT_ADDR);
    w_is_exit   = r_write && (r_dad == EXIT_ADDR);
    w_is_mmio   = w_is_stdout || w_is_exit ||
                  (!r_write && ((r_dad == STDOUT_ADDR) || (r_dad == EXIT_ADDR)));
    w_off       = {2'b00, r_dad} - {2'b00, DMEM_START};
    w_nbytes    = size_bytes(r_size);
    // Lowest byte index touched; half/byte lanes mirror within the word
    case (r_size)
      SZ_WORD: w_lo = w_off;
      SZ_HALF: w_lo = {w_off[XW-1:2], 2'b10} - {{(XW-2){1'b0}}, w_off[1:0]};
      default: w_lo = {w_off[XW-1:2], 2'b11} - {{(XW-2){1'b0}}, w_off[1:0]};
    endcase
    w_in_range = !w_lo[XW-1] &&
                 ((w_lo + {{(XW-3){1'b0}}, w_nbytes}) <= MEM_BYTES);
`ifdef DMEM_MISALIGN_CHK_EN
    w_misalign = ((r_size == SZ_WORD) && (r_dad[1:0] != 2'b00)) ||
                 ((r_size == SZ_HALF) && r_dad[0]);
`else
    w_misalign = 1'b0;
`endif
    w_err    = !w_is_mmio && (!w_in_range || w_misalign);
    w_mem_ok = !w_is_mmio && !w_err;
    w_idx0   = w_lo[DEPTH_LOG2-1:0];
    w_idx1   = w_lo[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
    w_idx2   = w_lo[DEPTH_LOG2-1:0] + DEPTH_LOG2'(2);
    w_idx3   = w_lo[DEPTH_LOG2-1:0] + DEPTH_LOG2'(3);
  end

  // Load data assembly; MMIO and erroring loads return zero
  always_comb begin
    w_rdata = '0;
    if (w_mem_ok && !r_write) begin
      case (r_size)
        SZ_WORD: w_rdata = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
        SZ_HALF: w_rdata = {16'h0000, r_mem[w_idx0], r_mem[w_idx1]};
        default: w_rdata = {24'h00_0000, r_mem[w_idx0]};
      endcase
    end
  end

  // Store into the byte array at the end of the ack cycle (contents survive reset)
  always_ff @(posedge clk) begin
    if (w_ack && r_write && w_mem_ok) begin
      case (r_size)
        SZ_WORD: begin
          r_mem[w_idx0] <= DDT[31:24];
          r_mem[w_idx1] <= DDT[23:16];
          r_mem[w_idx2] <= DDT[15:8];
          r_mem[w_idx3] <= DDT[7:0];
        end
        SZ_HALF: begin
          r_mem[w_idx0] <= DDT[15:8];
          r_mem[w_idx1] <= DDT[7:0];
        end
        default: begin
          r_mem[w_idx0] <= DDT[7:0];
        end
      endcase
    end
  end

  // Sticky exit request, set when an EXIT store completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exit <= 1'b0;
    end else if (w_ack && w_is_exit) begin
      r_exit <= 1'b1;
    end
  end

  assign DDT          = (w_ack && !r_write) ? w_rdata : {BIT_WIDTH{1'bz}};
  assign ACKD_n       = !w_ack;
  assign acc_err      = w_ack && w_err;
  assign stdout_valid = w_ack && w_is_stdout;
  assign stdout_char  = stdout_valid ? DDT[7:0] : 8'h00;
  assign exit_req     = r_exit;

endmodule
